mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the byte-serial MEM stage. Sits between EX/MEM and MEM/WB pipeline registers and drives the unified memory port.
- Executes RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a memory data bus BUS_BYTES wide.
- Supports misaligned accesses by splitting them into aligned beats, with per-beat write strobes.
- Holds the pipeline with stall_req_o until the access completes. Non-memory ops pass straight through.

Parameters:
- XLEN, 32: register and data width; only 32 is supported.
- ADDR_W, 32: byte address width.
- BUS_BYTES, 1: memory port width in bytes. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- opcode_i  in  7  opcode from EX; `LOAD_OP and `STORE_OP trigger an access.
- funct3_i  in  3  access size and signedness.
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  XLEN  ALU result, or store data for stores.
- mem_addr_i  in  ADDR_W  effective byte address.
- mem_rdata_i  in  8*BUS_BYTES  read data; valid one cycle after its address.
- wd_o  out  5  destination register to WB.
- wreg_o  out  1  register write enable to WB.
- wdata_o  out  XLEN  writeback data.
- stall_req_o  out  1  combinational pipeline hold request.
- mem_req_o  out  1  memory port active this cycle.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W  aligned beat address (low log2(BUS_BYTES) bits are 0).
- mem_wdata_o  out  8*BUS_BYTES  lane-positioned write data.
- mem_wstrb_o  out  BUS_BYTES  byte-lane write strobes.
- misalign_o  out  1  present only with MISALIGN_TRAP_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All registered outputs and internal registers are 0; mem_addr_o=0.
  - stall_req_o=0 while rst_n=0.
  - Reset mid-access aborts the access at that edge; no further write beats are issued.
- Access geometry:
  - size = 1/2/4 bytes from funct3.
  - off = mem_addr_i mod BUS_BYTES.
  - beats = ceil((off+size)/BUS_BYTES), range 1..4.
  - Beat k address = (mem_addr_i - off) + k*BUS_BYTES.
  - Address arithmetic wraps modulo 2^ADDR_W.
- FSM states:
  - IDLE: if the op is a load or store, latch size, off and beats, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive beat k with mem_req_o=1. Stores also drive mem_we_o=1 plus lane data and strobes. One beat per cycle.
  - Load pipelining: while issuing beat k+1, capture beat k data into its byte slots. A last-beat capture cycle (CAPT) follows the final issue.
  - DONE: one cycle with stall_req_o=0 and the result valid on wdata_o. Next state is IDLE.
- Latency:
  - Store: 1 (IDLE) + beats + 1 (DONE) cycles.
  - Load: 1 + beats + 1 (CAPT) + 1 cycles.
  - Aligned LW with BUS_BYTES=4 is 4 cycles total.
- stall_req_o = (op is load/store) && state!=DONE.
  - The input instruction must stay stable while stall_req_o=1.
  - In the cycle after DONE, the inputs are treated as a new instruction, even if identical.
- Load extension:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW takes bytes [31:0] little-endian.
- Store lanes: byte i of wdata_i goes to lane (off+i) mod BUS_BYTES of the beat covering it. The strobe is set only on those lanes.
- Reserved funct3 (load 3/6/7, store 3-7):
  - No memory access; goes directly to DONE.
  - wdata_o=0.
  - wreg_o passes through unchanged.
- Non-memory ops:
  - stall_req_o=0 and mem_req_o=0.
  - wdata_o=wdata_i combinationally.
- wd_o and wreg_o always follow wd_i and wreg_i combinationally.
- Outside ISSUE: mem_we_o=0, mem_wstrb_o=0, mem_req_o=0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - An access with mem_addr_i mod size != 0 issues no beats.
  - misalign_o=1 in its single DONE cycle; wdata_o=0 and wreg_o=0.
- Undefined:
  - Misaligned accesses split into beats as above.
  - The misalign_o port is absent.

Decomposition:
- Shared package (defines include) adds:
  - size encodings SZ_B, SZ_H, SZ_W;
  - FSM state encodings IDLE, ISSUE, CAPT, DONE.
- Existing shared defines are reused: `LOAD_OP, `STORE_OP, the funct3 codes, `ZeroWord.
- One sub-module: mem_lane_align. It is combinational and maps (off, beat index, size, data) to lane data, strobes and load byte-slot selects.
- The FSM and load capture registers live in mem_access_unit.

Test Plan:
- BUS_BYTES=1, SW 0xDEADBEEF at 0x100 -> writes EF,BE,AD,DE at 0x100..0x103 on consecutive cycles, strobe 1 each; stall_req_o high 5 cycles then low 1.
- BUS_BYTES=4, LH at 0x203 with memory 0x200=0x11223344, 0x204=0x55667788 -> 2 beats (0x200, 0x204); wdata_o=0x00008811 sign-extended to 0xFFFF8811.
- BUS_BYTES=4, SB 0xA5 at 0x302 -> one beat, addr 0x300, wstrb=4'b0100, wdata lane2=0xA5.
- BUS_BYTES=2, LBU at 0x401 reading 0x80 -> wdata_o=0x00000080; LB at the same address -> 0xFFFFFF80.
- Store beat 2 of 4 in flight, rst_n=0 -> next edge mem_we_o=0, state IDLE, no further writes.
- MISALIGN_TRAP_EN defined, LW at 0x502 -> no mem_req_o, misalign_o=1 for one cycle, wreg_o=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared opcode/funct3 defines plus the size and FSM
// state encodings used by the memory access unit and its lane aligner.
`ifndef LOAD_OP
`define LOAD_OP    7'b0000011
`endif
`ifndef STORE_OP
`define STORE_OP   7'b0100011
`endif
`ifndef FUNCT3_LB
`define FUNCT3_LB  3'b000
`define FUNCT3_LH  3'b001
`define FUNCT3_LW  3'b010
`define FUNCT3_LBU 3'b100
`define FUNCT3_LHU 3'b101
`define FUNCT3_SB  3'b000
`define FUNCT3_SH  3'b001
`define FUNCT3_SW  3'b010
`endif
`ifndef ZeroWord
`define ZeroWord   32'h00000000
`endif

package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational map from (offset, beat index, size, data) to
// per-lane write data, write strobes and load byte-slot selects. Lane j of
// beat k holds access byte (k*BUS_BYTES + j - off) when that index is inside
// the access.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int BUS_BYTES = 1,
  parameter int OFF_W     = 1
) (
  input  logic [OFF_W-1:0]             off_i,
  input  logic [2:0]                   beat_i,
  input  logic [2:0]                   nbytes_i,
  input  logic [31:0]                  data_i,
  output logic [8*BUS_BYTES-1:0]       lane_data_o,
  output logic [BUS_BYTES-1:0]         lane_strb_o,
  output logic [BUS_BYTES-1:0][1:0]    slot_sel_o
);

  localparam int SH = $clog2(BUS_BYTES);

  for (genvar j = 0; j < BUS_BYTES; j++) begin : g_lane
    logic [4:0] pos;
    logic [4:0] idx;
    logic       hit;

    assign pos = (5'(beat_i) << SH) + 5'(j);
    assign idx = pos - 5'(off_i);
    assign hit = (pos >= 5'(off_i)) && (idx < 5'(nbytes_i));

    assign lane_strb_o[j]         = hit;
    assign slot_sel_o[j]          = idx[1:0];
    assign lane_data_o[8*j +: 8]  = hit ? data_i[{idx[1:0], 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage executing RV32 loads/stores over a BUS_BYTES
// wide memory port, splitting misaligned accesses into aligned beats and
// holding the pipeline with stall_req_o until the access completes.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses trap instead
// of being split, reported on misalign_o).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode_i,
  input  logic [2:0]              funct3_i,
  input  logic [4:0]              wd_i,
  input  logic                    wreg_i,
  input  logic [XLEN-1:0]         wdata_i,
  input  logic [ADDR_W-1:0]       mem_addr_i,
  input  logic [8*BUS_BYTES-1:0]  mem_rdata_i,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         wdata_o,
  output logic                    stall_req_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*BUS_BYTES-1:0]  mem_wdata_o,
  output logic [BUS_BYTES-1:0]    mem_wstrb_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                    misalign_o
`endif
);

  localparam int OFF_W = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;
  localparam int SH    = $clog2(BUS_BYTES);

  if (!(BUS_BYTES == 1 || BUS_BYTES == 2 || BUS_BYTES == 4)) begin : g_bad_bus
    $error("mem_access_unit: BUS_BYTES must be 1, 2 or 4");
  end
  if (XLEN != 32) begin : g_bad_xlen
    $error("mem_access_unit: only XLEN=32 is supported");
  end

  // Sign/zero extension of the assembled load bytes.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input size_e sz,
                                           input logic sgn);
    case (sz)
      SZ_B:    return {{24{sgn & d[7]}}, d[7:0]};
      SZ_H:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_e              state_q;
  logic [2:0]          k_q;
  logic [2:0]          beats_q;
  logic [2:0]          nbytes_q;
  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   base_q;
  logic                ld_q;
  logic                sgn_q;
  size_e               sz_q;
  logic [31:0]         data_q;

  logic                is_ld, is_st, is_mem, rsv_in, skip_in;
  size_e               sz_in;
  logic [2:0]          nbytes_in;
  logic [OFF_W-1:0]    off_in;
  logic [3:0]          span;
  logic [2:0]          beats_in;
  logic [ADDR_W-1:0]   base_in;

  assign is_ld  = (opcode_i == `LOAD_OP);
  assign is_st  = (opcode_i == `STORE_OP);
  assign is_mem = is_ld | is_st;

  // Decode access size and reserved funct3 encodings.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   sz_in = SZ_B;
      2'b01:   sz_in = SZ_H;
      default: sz_in = SZ_W;
    endcase
    if (is_ld)
      rsv_in = !(funct3_i == `FUNCT3_LB  || funct3_i == `FUNCT3_LH ||
                 funct3_i == `FUNCT3_LW  || funct3_i == `FUNCT3_LBU ||
                 funct3_i == `FUNCT3_LHU);
    else
      rsv_in = !(funct3_i == `FUNCT3_SB || funct3_i == `FUNCT3_SH ||
                 funct3_i == `FUNCT3_SW);
  end

  if (BUS_BYTES == 1) begin : g_off1
    assign off_in = 1'b0;
  end else begin : g_offn
    assign off_in = mem_addr_i[OFF_W-1:0];
  end

  assign nbytes_in = size_bytes(sz_in);
  assign span      = 4'(off_in) + 4'(nbytes_in) + 4'(BUS_BYTES - 1);
  assign beats_in  = 3'(span >> SH);
  assign base_in   = mem_addr_i & ~ADDR_W'(BUS_BYTES - 1);

`ifdef MISALIGN_TRAP_EN
  logic mis_in;
  logic trap_q;

  // Natural-alignment test for the trap option.
  always_comb begin
    case (sz_in)
      SZ_B:    mis_in = 1'b0;
      SZ_H:    mis_in = mem_addr_i[0];
      default: mis_in = |mem_addr_i[1:0];
    endcase
  end
  assign skip_in = rsv_in | mis_in;
`else
  assign skip_in = rsv_in;
`endif

  logic [2:0]                 beat_sel;
  logic [8*BUS_BYTES-1:0]     lane_data;
  logic [BUS_BYTES-1:0]       lane_strb;
  logic [BUS_BYTES-1:0][1:0]  slot_sel;
  logic                       cap_en;

  // Stores align the beat being issued; loads align the beat whose data is
  // arriving, which is one behind the issue counter.
  assign beat_sel = ld_q ? (k_q - 3'd1) : k_q;
  assign cap_en   = ld_q && (((state_q == ISSUE) && (k_q != 3'd0)) || (state_q == CAPT));

  mem_lane_align #(
    .BUS_BYTES (BUS_BYTES),
    .OFF_W     (OFF_W)
  ) u_align (
    .off_i       (off_q),
    .beat_i      (beat_sel),
    .nbytes_i    (nbytes_q),
    .data_i      (wdata_i),
    .lane_data_o (lane_data),
    .lane_strb_o (lane_strb),
    .slot_sel_o  (slot_sel)
  );

  // Access sequencer: latch geometry, step one beat per cycle, capture load bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      beats_q  <= '0;
      nbytes_q <= '0;
      off_q    <= '0;
      base_q   <= '0;
      ld_q     <= 1'b0;
      sgn_q    <= 1'b0;
      sz_q     <= SZ_B;
      data_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      if (cap_en) begin
        for (int j = 0; j < BUS_BYTES; j++) begin
          if (lane_strb[j]) data_q[{slot_sel[j], 3'b000} +: 8] <= mem_rdata_i[8*j +: 8];
        end
      end
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            off_q    <= off_in;
            base_q   <= base_in;
            beats_q  <= beats_in;
            nbytes_q <= nbytes_in;
            sz_q     <= sz_in;
            sgn_q    <= ~funct3_i[2];
            k_q      <= '0;
            data_q   <= '0;
            ld_q     <= is_ld & ~skip_in;
            state_q  <= skip_in ? DONE : ISSUE;
`ifdef MISALIGN_TRAP_EN
            trap_q   <= mis_in & ~rsv_in;
`endif
          end
        end
        ISSUE: begin
          k_q <= k_q + 3'd1;
          if (k_q == beats_q - 3'd1) state_q <= ld_q ? CAPT : DONE;
        end
        CAPT: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
`ifdef MISALIGN_TRAP_EN
          trap_q  <= 1'b0;
`endif
        end
      endcase
    end
  end

  logic issue, st_beat;
  assign issue   = (state_q == ISSUE);
  assign st_beat = issue & ~ld_q;

  assign mem_req_o   = issue;
  assign mem_we_o    = st_beat;
  assign mem_addr_o  = issue ? (base_q + (ADDR_W'(k_q) << SH)) : '0;
  assign mem_wdata_o = st_beat ? lane_data : '0;
  assign mem_wstrb_o = st_beat ? lane_strb : '0;

  assign stall_req_o = rst_n && is_mem && (state_q != DONE);
  assign wd_o        = wd_i;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o  = trap_q && (state_q == DONE);
  assign wreg_o      = wreg_i & ~misalign_o;
`else
  assign wreg_o      = wreg_i;
`endif

  // Writeback mux: ALU result for non-memory ops, extended load data in DONE.
  always_comb begin
    if (!is_mem)
      wdata_o = wdata_i;
    else if ((state_q == DONE) && ld_q)
      wdata_o = load_ext(data_q, sz_q, sgn_q);
    else
      wdata_o = `ZeroWord;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: three instances (BUS_BYTES = 1, 2, 4) each
// driven with directed and random load/store traffic and compared against a
// byte-level memory model.
module tb_mem_access_unit;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int BB = 1 << g;

    logic              rst_n;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic [4:0]        wd;
    logic              wreg;
    logic [31:0]       wdata, addr;
    logic [8*BB-1:0]   rdata;
    logic [4:0]        o_wd;
    logic              o_wreg;
    logic [31:0]       o_wdata;
    logic              stall, mreq, mwe;
    logic [31:0]       maddr;
    logic [8*BB-1:0]   mwdata;
    logic [BB-1:0]     mstrb;
`ifdef MISALIGN_TRAP_EN
    logic              mis;
`endif
    bit                fin_l = 1'b0;
    int                cyc   = 0;
    logic              pend  = 1'b0;
    logic [31:0]       pend_a = '0;
    beat_t             log_q[$];
    logic [7:0]        mem [logic [31:0]];

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .BUS_BYTES(BB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode_i    (op),
      .funct3_i    (f3),
      .wd_i        (wd),
      .wreg_i      (wreg),
      .wdata_i     (wdata),
      .mem_addr_i  (addr),
      .mem_rdata_i (rdata),
      .wd_o        (o_wd),
      .wreg_o      (o_wreg),
      .wdata_o     (o_wdata),
      .stall_req_o (stall),
      .mem_req_o   (mreq),
      .mem_we_o    (mwe),
      .mem_addr_o  (maddr),
      .mem_wdata_o (mwdata),
`ifdef MISALIGN_TRAP_EN
      .misalign_o  (mis),
`endif
      .mem_wstrb_o (mstrb)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory port model: log every beat, return read data one cycle later.
    always @(negedge clk) begin
      if (mreq === 1'b1) log_q.push_back('{cyc, mwe, maddr, 32'(mwdata), 4'(mstrb)});
      for (int j = 0; j < BB; j++)
        rdata[8*j +: 8] <= pend ? rd(pend_a + 32'(j)) : 8'($urandom);
      pend   <= (mreq === 1'b1) && (mwe === 1'b0);
      pend_a <= maddr;
    end

    task automatic run(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rdst, input logic wen);
      bit          ld, st, rsv, trap;
      int          sz, off, beats, nst, n, gp;
      logic [31:0] v, expv, base;
      logic [31:0] bd [4];
      logic [3:0]  bs [4];
      beat_t       e[$];
      string       tg;

      ld    = (o == OP_LD);
      st    = (o == OP_ST);
      rsv   = ld ? (f == 3'd3 || f >= 3'd6) : (f >= 3'd3);
      sz    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      off   = int'(a % BB);
      beats = (off + sz + BB - 1) / BB;
      base  = a - 32'(off);
      trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap  = (ld || st) && !rsv && ((a % sz) != 0);
`endif
      tg = $sformatf("bb%0d op%h f%0d a%h", BB, o, f, a);

      nst = (!ld && !st) ? 0 : (rsv || trap) ? 1 : st ? 1 + beats : 2 + beats;

      for (int b = 0; b < 4; b++) begin bd[b] = '0; bs[b] = '0; end
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rd(a + 32'(i));
      case (f)
        3'd0:    expv = {{24{v[7]}}, v[7:0]};
        3'd1:    expv = {{16{v[15]}}, v[15:0]};
        default: expv = v;
      endcase
      if (rsv || trap) expv = '0;

      if ((ld || st) && !rsv && !trap) begin
        for (int i = 0; i < sz; i++) begin
          gp = off + i;
          bd[gp / BB][8*(gp % BB) +: 8] = d[8*i +: 8];
          bs[gp / BB][gp % BB] = 1'b1;
        end
        for (int b = 0; b < beats; b++)
          e.push_back('{0, st, base + 32'(b * BB), st ? bd[b] : 32'h0, st ? bs[b] : 4'h0});
      end

      @(posedge clk); #1;
      op = o; f3 = f; addr = a; wdata = d; wd = rdst; wreg = wen;
      log_q.delete();

      if (!ld && !st) begin
        @(negedge clk);
        chk({tg, " alu_stall"}, stall, 1'b0);
        chk({tg, " alu_req"}, mreq, 1'b0);
        chk({tg, " alu_wdata"}, o_wdata, d);
        chk({tg, " alu_wd"}, o_wd, rdst);
        chk({tg, " alu_wreg"}, o_wreg, wen);
        return;
      end

      @(negedge clk);
      n = 0;
      while (stall === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk({tg, " stall_cycles"}, 64'(n), 64'(nst));
      if (n < 20) begin
        if (ld || rsv || trap) chk({tg, " wdata"}, o_wdata, expv);
        chk({tg, " wreg"}, o_wreg, trap ? 1'b0 : wen);
        chk({tg, " wd"}, o_wd, rdst);
`ifdef MISALIGN_TRAP_EN
        chk({tg, " misalign"}, mis, trap);
`endif
      end
      @(posedge clk); #1;
      op = OP_ALU;

      chk({tg, " nbeats"}, 64'(log_q.size()), 64'(e.size()));
      for (int i = 0; i < e.size() && i < log_q.size(); i++) begin
        chk($sformatf("%s b%0d addr", tg, i), log_q[i].a, e[i].a);
        chk($sformatf("%s b%0d we", tg, i), log_q[i].we, e[i].we);
        chk($sformatf("%s b%0d cyc", tg, i), 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
        if (st) begin
          chk($sformatf("%s b%0d data", tg, i), log_q[i].d, e[i].d);
          chk($sformatf("%s b%0d strb", tg, i), log_q[i].s, e[i].s);
        end
      end
      if (st && !rsv && !trap)
        for (int i = 0; i < sz; i++) mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic abort_test();
      logic [31:0] a;
      int          off, gp;
      a   = 32'h0000_0601;
      off = int'(a % BB);
      @(posedge clk); #1;
      op = OP_ST; f3 = 3'd2; addr = a; wdata = 32'h1122_3344; wd = 5'd0; wreg = 1'b0;
      log_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("bb%0d abort_stall_in_rst", BB), stall, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1; op = OP_ALU;
      @(negedge clk);
      chk($sformatf("bb%0d abort_we", BB), mwe, 1'b0);
      chk($sformatf("bb%0d abort_req", BB), mreq, 1'b0);
      chk($sformatf("bb%0d abort_strb", BB), 4'(mstrb), 4'h0);
      repeat (4) @(negedge clk);
      chk($sformatf("bb%0d abort_nbeats", BB), 64'(log_q.size()), 64'd2);
      for (int i = 0; i < 4; i++) begin
        gp = off + i;
        if (gp / BB < 2) mem[a + 32'(i)] = 8'(32'h1122_3344 >> (8 * i));
      end
    endtask

    initial begin
      logic [6:0]  ro;
      logic [31:0] ra;
      int          r;
      rst_n = 1'b0; op = OP_ST; f3 = 3'd2; addr = 32'h100; wdata = '0; wd = '0; wreg = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("bb%0d rst_stall", BB), stall, 1'b0);
      chk($sformatf("bb%0d rst_req", BB), mreq, 1'b0);
      chk($sformatf("bb%0d rst_we", BB), mwe, 1'b0);
      chk($sformatf("bb%0d rst_addr", BB), maddr, 32'h0);
      chk($sformatf("bb%0d rst_strb", BB), 4'(mstrb), 4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; op = OP_ALU;

      for (int i = 0; i < 4; i++) begin
        mem[32'h200 + 32'(i)] = 8'(32'h1122_3344 >> (8 * i));
        mem[32'h204 + 32'(i)] = 8'(32'h5566_7788 >> (8 * i));
      end
      mem[32'h401] = 8'h80;

      run(OP_ST,  3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 1'b0);
      run(OP_LD,  3'd1, 32'h0000_0203, 32'h0,         5'd2, 1'b1);
      run(OP_ST,  3'd0, 32'h0000_0302, 32'h1234_56A5, 5'd3, 1'b0);
      run(OP_LD,  3'd4, 32'h0000_0401, 32'h0,         5'd4, 1'b1);
      run(OP_LD,  3'd0, 32'h0000_0401, 32'h0,         5'd5, 1'b1);
      run(OP_ALU, 3'd0, 32'h0000_0000, 32'hCAFE_F00D, 5'd6, 1'b1);
      run(OP_LD,  3'd3, 32'h0000_0200, 32'h0,         5'd7, 1'b1);
      run(OP_ST,  3'd5, 32'h0000_0200, 32'h0,         5'd8, 1'b0);
      run(OP_LD,  3'd2, 32'h0000_0100, 32'h0,         5'd9, 1'b1);
      run(OP_LD,  3'd2, 32'hFFFF_FFFE, 32'h0,         5'd10, 1'b1);
      run(OP_ST,  3'd1, 32'hFFFF_FFFF, 32'hBEEF_7A5C, 5'd11, 1'b0);
      run(OP_LD,  3'd5, 32'hFFFF_FFFF, 32'h0,         5'd12, 1'b1);
      abort_test();
      run(OP_LD,  3'd2, 32'h0000_0600, 32'h0,         5'd13, 1'b1);
      run(OP_LD,  3'd2, 32'h0000_0502, 32'h0,         5'd14, 1'b1);

      for (int t = 0; t < 60; t++) begin
        r  = int'($urandom_range(0, 9));
        ro = (r < 4) ? OP_LD : (r < 8) ? OP_ST : OP_ALU;
        ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                         : 32'h0000_1000 + 32'($urandom_range(0, 255));
        run(ro, 3'($urandom_range(0, 7)), ra, $urandom, 5'($urandom), 1'($urandom));
      end
      fin_l = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(u[0].fin_l && u[1].fin_l && u[2].fin_l) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("all_done", {u[0].fin_l, u[1].fin_l, u[2].fin_l}, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
